// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpDiv  = 3'b011;
  localparam logic [2:0] OpSub  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpSlt  = 3'b110;
  localparam logic [2:0] OpSltu = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} alu_state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  // opa: multiplicand (MUL) or dividend shifting into quotient (DIV)
  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] opa_q, opa_d;
  logic [Width-1:0] opb_q, opb_d;
  logic [Width:0]   rem_shift, rem_diff;

  always_comb begin
    busy_d    = busy_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_shift = {acc_q, opa_q[Width-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    if (start_i) begin
      busy_d   = 1'b1;
      is_div_d = (op_i == OpDiv);
      cnt_d    = CntW'(Width);
      acc_d    = '0;
      opa_d    = a_i;
      opb_d    = b_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          // A zero divisor never borrows, so the quotient fills with ones.
          if (!rem_diff[Width]) begin
            acc_d = rem_diff[Width-1:0];
            opa_d = {opa_q[Width-2:0], 1'b1};
          end else begin
            acc_d = rem_shift[Width-1:0];
            opa_d = {opa_q[Width-2:0], 1'b0};
          end
        end else begin
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = is_div_q ? opa_q : acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: logic/add/sub/compare in one cycle, MUL/DIV over WIDTH+1 cycles.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             ZeroFlag,
  output logic             OverflowFlag,
  output logic             DivZeroFlag
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, dz_q, dz_d, valid_q, valid_d;

  logic             start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] sum, diff, single_res;
  logic             single_ovf;

  assign start = (state_q == StIdle) && InValid && is_iter_op(ALUControl);

  alu_iter_unit #(
    .Width(WIDTH)
  ) u_iter (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (start),
    .op_i    (ALUControl),
    .a_i     (SrcA),
    .b_i     (SrcB),
    .done_o  (iter_done),
    .result_o(iter_result)
  );

  always_comb begin
    sum        = a_q + b_q;
    diff       = a_q - b_q;
    single_res = '0;
    single_ovf = 1'b0;
    case (op_q)
      OpAnd:  single_res = a_q & b_q;
      OpOr:   single_res = a_q | b_q;
      OpAdd: begin
        single_res = sum;
        single_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        single_res = diff;
        single_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSlt:  single_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OpSltu: single_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    valid_d  = valid_q;
    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          a_d  = SrcA;
          b_d  = SrcB;
          op_d = ALUControl;
          if (ALUControl == OpMul)      state_d = StMul;
          else if (ALUControl == OpDiv) state_d = StDiv;
          else                          state_d = StDone;
        end
      end
      StMul, StDiv: begin
        if (iter_done) begin
          result_d = iter_result;
          ovf_d    = 1'b0;
          dz_d     = (state_q == StDiv) && (b_q == '0);
          valid_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        // Single-cycle ops arrive here with valid low and capture on this cycle.
        if (!valid_q) begin
          result_d = single_res;
          ovf_d    = single_ovf;
          dz_d     = 1'b0;
          valid_d  = 1'b1;
        end else if (OutReady) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAnd;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      valid_q  <= valid_d;
    end
  end

  assign InReady      = (state_q == StIdle);
  assign OutValid     = valid_q;
  assign ALUResult    = result_q;
  assign ZeroFlag     = (result_q == '0);
  assign OverflowFlag = ovf_q;
  assign DivZeroFlag  = dz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu with a queue of expected results.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] src_a, src_b, alu_result;
  logic [2:0]   alu_control;
  logic         zero_flag, ovf_flag, dz_flag;

  always #5 clk = ~clk;

  multicycle_alu #(
    .WIDTH(W)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .SrcA        (src_a),
    .SrcB        (src_b),
    .ALUControl  (alu_control),
    .OutValid    (out_valid),
    .OutReady    (out_ready),
    .ALUResult   (alu_result),
    .ZeroFlag    (zero_flag),
    .OverflowFlag(ovf_flag),
    .DivZeroFlag (dz_flag)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         zf;
    logic         of;
    logic         dzf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    e.of  = 1'b0;
    e.dzf = 1'b0;
    e.lat = 1;
    r     = '0;
    case (op)
      OpAnd: r = a & b;
      OpOr:  r = a | b;
      OpAdd: begin
        r    = a + b;
        e.of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OpSub: begin
        r    = a - b;
        e.of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OpMul: begin
        r     = a * b;
        e.lat = W + 1;
      end
      OpDiv: begin
        e.lat = W + 1;
        if (b == '0) begin
          r     = '1;
          e.dzf = 1'b1;
        end else begin
          r = a / b;
        end
      end
      OpSlt:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      OpSltu: r = (a < b) ? 1 : 0;
      default: r = '0;
    endcase
    e.res = r;
    e.zf  = (r == '0);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit ack, output logic [W-1:0] got);
    exp_t e;
    int   cyc;
    got = 'x;
    @(negedge clk);
    check({tag, "_inready"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    src_a       = a;
    src_b       = b;
    alu_control = op;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_result"}, 64'(alu_result), 64'(e.res));
    check({tag, "_zero"}, 64'(zero_flag), 64'(e.zf));
    check({tag, "_ovf"}, 64'(ovf_flag), 64'(e.of));
    check({tag, "_divzero"}, 64'(dz_flag), 64'(e.dzf));
    got = alu_result;
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle_inready"}, 64'(in_ready), 64'd1);
      check({tag, "_idle_outvalid"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got, held_res;
    logic         held_z, held_o, held_d, seen;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    src_a = '0;
    src_b = '0;
    alu_control = OpAnd;
    repeat (3) @(negedge clk);
    check("rst_inready", 64'(in_ready), 64'd1);
    check("rst_outvalid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(alu_result), 64'd0);
    check("rst_zero", 64'(zero_flag), 64'd1);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    check("rst_divzero", 64'(dz_flag), 64'd0);
    rst = 1'b0;

    run_op("add_ovf", OpAdd, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, got);
    check("add_ovf_const", 64'(got), 64'h8000_0000);
    run_op("mul_wrap", OpMul, 32'h0001_0000, 32'h0001_0000, 1'b1, got);
    check("mul_wrap_const", 64'(got), 64'd0);
    run_op("mul_7x6", OpMul, 32'd7, 32'd6, 1'b1, got);
    check("mul_7x6_const", 64'(got), 64'd42);
    run_op("div_100_7", OpDiv, 32'd100, 32'd7, 1'b1, got);
    check("div_100_7_const", 64'(got), 64'd14);
    run_op("div_by0", OpDiv, 32'd5, 32'd0, 1'b1, got);
    check("div_by0_const", 64'(got), 64'hFFFF_FFFF);
    run_op("slt", OpSlt, 32'hFFFF_FFFF, 32'd1, 1'b1, got);
    check("slt_const", 64'(got), 64'd1);
    run_op("sltu", OpSltu, 32'hFFFF_FFFF, 32'd1, 1'b1, got);
    check("sltu_const", 64'(got), 64'd0);
    run_op("sub_ovf", OpSub, 32'h8000_0000, 32'd1, 1'b1, got);
    run_op("sub_zero", OpSub, 32'h1234_5678, 32'h1234_5678, 1'b1, got);
    run_op("and", OpAnd, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, got);
    run_op("or", OpOr, 32'hF000_0001, 32'h0000_1000, 1'b1, got);
    for (int i = 0; i < 2; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("mul_rand", OpMul, ra, rb, 1'b1, got);
      run_op("div_rand", OpDiv, ra, rb >> (i * 16), 1'b1, got);
    end

    // Result must stay put in DONE while the consumer stalls.
    run_op("hold", OpAdd, 32'd10, 32'd20, 1'b0, got);
    held_res = alu_result;
    held_z   = zero_flag;
    held_o   = ovf_flag;
    held_d   = dz_flag;
    for (int i = 0; i < 5; i++) begin
      in_valid    = 1'b1;
      alu_control = OpSub;
      src_a       = 32'd99;
      @(negedge clk);
      check("hold_result", 64'(alu_result), 64'(held_res));
      check("hold_flags", 64'({zero_flag, ovf_flag, dz_flag}), 64'({held_z, held_o, held_d}));
      check("hold_outvalid", 64'(out_valid), 64'd1);
      check("hold_inready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_inready", 64'(in_ready), 64'd1);
    check("release_outvalid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("ignored_no_result", 64'(seen), 64'd0);

    // Reset part-way through a MUL, colliding with a new request.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = OpMul;
    src_a       = 32'd7;
    src_b       = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst         = 1'b1;
    in_valid    = 1'b1;
    alu_control = OpAdd;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_outvalid", 64'(out_valid), 64'd0);
    check("abort_inready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(alu_result), 64'd0);
    check("abort_zero", 64'(zero_flag), 64'd1);
    seen = 1'b0;
    repeat (2 * W) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op("post_rst_add", OpAdd, 32'd2, 32'd3, 1'b1, got);
    check("post_rst_add_const", 64'(got), 64'd5);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
